// File: rtl/ipf_pkg.sv
// ipf_pkg: shared geometry, control encodings and format helpers for the
// ipf 3x3 input-times-filter product engine.
//   IN_W    element width of pixels and weights
//   TAPS    kernel taps per window (3x3)
//   FILT    filters per weight word
//   COLS    pixels per input row
//   PROD_W  width of one packed product field
//   RES_W   full result word: FILT*COLS*TAPS*PROD_W bits
package ipf_pkg;

  localparam int IN_W    = 8;
  localparam int TAPS    = 9;
  localparam int FILT    = 8;
  localparam int COLS    = 8;
  localparam int PROD_W  = 16;
  localparam int KDIM    = 3;
  localparam int ROW_W   = COLS * IN_W;            // 64
  localparam int SLICE_W = COLS * TAPS * PROD_W;   // one filter's products
  localparam int RES_W   = FILT * SLICE_W;         // 9216

  localparam logic [1:0] CTRL_END   = 2'd0;
  localparam logic [1:0] CTRL_START = 2'd1;
  localparam logic [1:0] CTRL_HOLD  = 2'd2;

  localparam logic [3:0] FMT_SIGNED = 4'd2;

  // Any format other than the signed code is treated as unsigned.
  function automatic logic fmt_is_signed(input logic [3:0] fmt);
    return fmt == FMT_SIGNED;
  endfunction

endpackage

// File: rtl/ipf_if.sv
// ipf_if: bundles the ipf control, row/weight streams, reserved mode inputs
// and the result outputs.
//   master: producer side (line buffers / bench) drives inputs, sees results
//   slave : the ipf engine
interface ipf_if;
  import ipf_pkg::*;

  logic [1:0]       ctrl;
  logic             i_valid;
  logic [ROW_W-1:0] i_data;
  logic             w_valid;
  logic [ROW_W-1:0] w_data;
  logic [1:0]       Wsize;
  logic [3:0]       i_format;
  logic [3:0]       w_format;
  logic [1:0]       RLPadding;
  logic             stride;
  logic [3:0]       wgroup;
  logic [2:0]       wround;
  logic             res_valid;
  logic [RES_W-1:0] result;

  modport master (
    output ctrl, i_valid, i_data, w_valid, w_data, Wsize, i_format, w_format,
           RLPadding, stride, wgroup, wround,
    input  res_valid, result
  );

  modport slave (
    input  ctrl, i_valid, i_data, w_valid, w_data, Wsize, i_format, w_format,
           RLPadding, stride, wgroup, wround,
    output res_valid, result
  );

endinterface

// File: rtl/ipf_mac_slice.sv
// ipf_mac_slice: combinational multiplier array for one filter.
// Produces COLS x TAPS products of the filter's tap weights against the
// 3-row window; columns that run past the right edge see a zero pixel.
//   w_i        tap weights for this filter, index t = 3*ky + kx
//   rows_i     window rows, index ky (0 = top)
//   w_signed_i weights are two's complement when set
//   i_signed_i pixels are two's complement when set
//   prod_o     field (c*TAPS + t) holds the 16-bit truncated product
module ipf_mac_slice
  import ipf_pkg::*;
(
  input  logic [TAPS-1:0][IN_W-1:0]  w_i,
  input  logic [KDIM-1:0][ROW_W-1:0] rows_i,
  input  logic                       w_signed_i,
  input  logic                       i_signed_i,
  output logic [SLICE_W-1:0]         prod_o
);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
      localparam int KY = t / KDIM;
      localparam int KX = t % KDIM;

      logic [IN_W-1:0]          px;
      logic signed [PROD_W-1:0] a, b, p;

      if (c + KX < COLS) begin : g_in
        assign px = rows_i[KY][(c+KX)*IN_W +: IN_W];
      end else begin : g_pad
        assign px = '0;
      end

      // Extending both operands to the product width makes the low 16
      // bits of a 16x16 multiply exact for every sign combination.
      assign a = {{(PROD_W-IN_W){w_signed_i & w_i[t][IN_W-1]}}, w_i[t]};
      assign b = {{(PROD_W-IN_W){i_signed_i & px[IN_W-1]}}, px};
      assign p = a * b;

      assign prod_o[(c*TAPS + t)*PROD_W +: PROD_W] = p;
    end
  end

endmodule

// File: rtl/ipf.sv
// ipf: 3x3 convolution partial-product generator.
// Latches nine 64-bit tap words, shifts 8-pixel rows through a 3-row
// window and, whenever an incoming row completes a window under START,
// registers all 8 filters x 8 columns x 9 taps products as one word.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         ipf_if.slave: ctrl, row/weight streams, formats, reserved
//               mode inputs, res_valid pulse and result word
module ipf
  import ipf_pkg::*;
#(
  parameter int In_Width   = 8,
  parameter int Out_Width  = 9,
  parameter int Addr_Width = 16
) (
  input logic   clk,
  input logic   rst_n,
  ipf_if.slave  bus
);

  localparam logic [3:0] TAPS_L = 4'(TAPS);

  logic [TAPS-1:0][ROW_W-1:0] w_q, w_d;
  logic [3:0]                 wptr_q, wptr_d;
  logic [KDIM-1:0][ROW_W-1:0] row_q, row_d;   // [0] oldest, [2] newest
  logic [1:0]                 fill_q, fill_d;
  logic                       res_valid_q;
  logic [RES_W-1:0]           result_q;

  logic                       fire;
  logic                       w_sgn, i_sgn;
  logic [RES_W-1:0]           prod;
  logic [KDIM-1:0][ROW_W-1:0] win;
  logic [FILT-1:0][TAPS-1:0][IN_W-1:0] w_by_f;

  // Weight load: a burst of w_valid cycles fills taps 0,1,2..; any idle
  // cycle rewinds the pointer, and extra words in a burst are dropped.
  always_comb begin
    w_d    = w_q;
    wptr_d = wptr_q;
    if (bus.w_valid) begin
      if (wptr_q < TAPS_L) begin
        w_d[wptr_q] = bus.w_data;
        wptr_d      = wptr_q + 4'd1;
      end
    end else begin
      wptr_d = '0;
    end
  end

  // Row window. A non-START ctrl (including X) never fires; END drops the
  // fill count without shifting so the next window starts from scratch.
  assign fire = bus.i_valid && (bus.ctrl == CTRL_START) && (fill_q >= 2'd2);

  always_comb begin
    row_d  = row_q;
    fill_d = fill_q;
    if (bus.ctrl == CTRL_END) begin
      fill_d = '0;
    end else if (bus.i_valid) begin
      row_d  = {bus.i_data, row_q[2], row_q[1]};
      fill_d = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
    end
  end

  // The incoming row is the bottom of the window, so products are formed
  // from the pre-edge buffer plus i_data and the pre-edge weights.
  assign win   = {bus.i_data, row_q[2], row_q[1]};
  assign w_sgn = fmt_is_signed(bus.w_format);
  assign i_sgn = fmt_is_signed(bus.i_format);

  for (genvar f = 0; f < FILT; f++) begin : g_filt
    for (genvar t = 0; t < TAPS; t++) begin : g_wsel
      assign w_by_f[f][t] = w_q[t][f*IN_W +: IN_W];
    end

    ipf_mac_slice u_slice (
      .w_i        (w_by_f[f]),
      .rows_i     (win),
      .w_signed_i (w_sgn),
      .i_signed_i (i_sgn),
      .prod_o     (prod[f*SLICE_W +: SLICE_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q         <= '0;
      wptr_q      <= '0;
      row_q       <= '0;
      fill_q      <= '0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      w_q         <= w_d;
      wptr_q      <= wptr_d;
      row_q       <= row_d;
      fill_q      <= fill_d;
      res_valid_q <= fire;
      if (fire) result_q <= prod;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;

  // Reserved mode inputs, the oldest row and the geometry parameters have
  // no effect on the datapath; only 3x3 kernels are built.
  logic unused_ok;
  assign unused_ok = ^{bus.Wsize, bus.RLPadding, bus.stride, bus.wgroup,
                       bus.wround, row_q[0], 32'(In_Width), 32'(Out_Width),
                       32'(Addr_Width)};

endmodule

// File: tb/tb_ipf.sv
module tb_ipf;
  import ipf_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ipf_if bus();

  ipf #(.In_Width(8), .Out_Width(9), .Addr_Width(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int pulses;

  logic [63:0]      tw [9];
  logic [15:0]      fv [9];
  logic [RES_W-1:0] exp_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.ctrl = CTRL_HOLD; bus.i_valid = 1'b0; bus.i_data = '0;
    bus.w_valid = 1'b0; bus.w_data = '0; bus.Wsize = '0;
    bus.i_format = '0; bus.w_format = '0; bus.RLPadding = '0;
    bus.stride = 1'b0; bus.wgroup = '0; bus.wround = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_bus();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Burst of n weight words; words past tap 8 carry junk that must be dropped.
  task automatic load_w(input int n);
    for (int i = 0; i < n; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = (i < 9) ? tw[i] : 64'hA5A5_5A5A_DEAD_BEEF;
      tick();
    end
    bus.w_valid = 1'b0;
    tick();
  endtask

  task automatic row(input logic [63:0] d, input logic [1:0] c);
    bus.i_valid = 1'b1; bus.i_data = d; bus.ctrl = c;
    tick();
    bus.i_valid = 1'b0; bus.ctrl = CTRL_HOLD;
    if (bus.res_valid === 1'b1) pulses++;
  endtask

  // Expected word from per-tap constants fv[], zero where c+kx runs off the row.
  function automatic logic [RES_W-1:0] build();
    logic [RES_W-1:0] v;
    v = '0;
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 8; c++)
        for (int t = 0; t < 9; t++)
          if (c + t % 3 <= 7) v[((f*8 + c)*9 + t)*16 +: 16] = fv[t];
    return v;
  endfunction

  function automatic logic [RES_W-1:0] model(input logic [63:0] ra, rb, rc,
                                             input bit ws, input bit is);
    logic [RES_W-1:0] v;
    logic [63:0] rw;
    logic [7:0]  wb, pb;
    int a, b, p;
    v = '0;
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 8; c++)
        for (int t = 0; t < 9; t++) begin
          rw = (t / 3 == 0) ? ra : (t / 3 == 1) ? rb : rc;
          pb = (c + t % 3 <= 7) ? rw[8*(c + t % 3) +: 8] : 8'h00;
          wb = tw[t][8*f +: 8];
          a  = ws ? int'($signed(wb)) : int'(wb);
          b  = is ? int'($signed(pb)) : int'(pb);
          p  = a * b;
          v[((f*8 + c)*9 + t)*16 +: 16] = p[15:0];
        end
    return v;
  endfunction

  function automatic int first_diff(input logic [RES_W-1:0] x, y);
    for (int i = 0; i < RES_W/16; i++)
      if (x[i*16 +: 16] !== y[i*16 +: 16]) return i;
    return 0;
  endfunction

  task automatic test_reset();
    int fi;
    rst_n = 1'b0;
    idle_bus();
    repeat (2) tick();
    total++;
    if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", bus.res_valid);
    end
    total++;
    if (bus.result !== '0) begin
      bad++; fi = first_diff(bus.result, '0);
      $display("FAIL reset_result: field %0d got %h want 0000", fi, bus.result[fi*16 +: 16]);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ones();
    logic [63:0] d;
    int fi;
    do_reset();
    for (int t = 0; t < 9; t++) tw[t] = {8{8'h01}};
    load_w(9);
    pulses = 0;
    for (int r = 0; r < 8; r++) begin
      d = {8{8'(r + 1)}};
      row(d, (r < 2) ? CTRL_HOLD : CTRL_START);
      total++;
      if (bus.res_valid !== (r >= 2)) begin
        bad++; $display("FAIL ones_valid row%0d: got %b want %b", r, bus.res_valid, r >= 2);
      end
      if (r >= 2) begin
        for (int t = 0; t < 9; t++) fv[t] = 16'(r - 1 + t / 3);
        exp_v = build();
        total++;
        if (bus.result !== exp_v) begin
          bad++; fi = first_diff(bus.result, exp_v);
          $display("FAIL ones_result win%0d: field %0d got %h want %h", r - 2, fi,
                   bus.result[fi*16 +: 16], exp_v[fi*16 +: 16]);
        end
      end
    end
    total++;
    if (pulses != 6) begin
      bad++; $display("FAIL ones_pulses: got %0d want 6", pulses);
    end
    tick();
    total++;
    if (bus.res_valid !== 1'b0) begin
      bad++; $display("FAIL ones_idle_valid: got %b want 0", bus.res_valid);
    end
    total++;
    if (bus.result !== exp_v) begin
      bad++; fi = first_diff(bus.result, exp_v);
      $display("FAIL ones_hold_result: field %0d got %h want %h", fi,
               bus.result[fi*16 +: 16], exp_v[fi*16 +: 16]);
    end
  endtask

  task automatic test_signed();
    // wf, if, weight byte, pixel byte, expected product
    logic [3:0]  wf [6] = '{4'd2, 4'd1, 4'd2, 4'd0, 4'd0, 4'd2};
    logic [3:0]  xf [6] = '{4'd2, 4'd1, 4'd2, 4'd2, 4'd0, 4'd0};
    logic [7:0]  wb [6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80};
    logic [7:0]  pb [6] = '{8'h80, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'hFF};
    logic [15:0] ex [6] = '{16'h0080, 16'hFE01, 16'h0001, 16'h8080, 16'h7F80, 16'h8080};
    int fi;
    for (int m = 0; m < 6; m++) begin
      do_reset();
      bus.w_format = wf[m]; bus.i_format = xf[m];
      for (int t = 0; t < 9; t++) tw[t] = {8{wb[m]}};
      load_w(9);
      row({8{pb[m]}}, CTRL_HOLD);
      row({8{pb[m]}}, CTRL_HOLD);
      row({8{pb[m]}}, CTRL_START);
      total++;
      if (bus.res_valid !== 1'b1) begin
        bad++; $display("FAIL signed_valid case%0d: got %b want 1", m, bus.res_valid);
      end
      for (int t = 0; t < 9; t++) fv[t] = ex[m];
      exp_v = build();
      total++;
      if (bus.result !== exp_v) begin
        bad++; fi = first_diff(bus.result, exp_v);
        $display("FAIL signed_result case%0d: field %0d got %h want %h", m, fi,
                 bus.result[fi*16 +: 16], exp_v[fi*16 +: 16]);
      end
    end
  endtask

  task automatic test_hold_end();
    int fi;
    do_reset();
    for (int t = 0; t < 9; t++) tw[t] = {8{8'h01}};
    load_w(9);
    pulses = 0;
    row({8{8'd1}}, CTRL_HOLD);
    row({8{8'd2}}, CTRL_HOLD);
    row({8{8'd3}}, CTRL_HOLD);
    row({8{8'd4}}, 2'd3);
    row({8{8'd5}}, CTRL_HOLD);
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL hold_pulses: got %0d want 0", pulses);
    end
    row({8{8'd9}}, CTRL_END);
    row({8{8'd6}}, CTRL_START);
    row({8{8'd7}}, CTRL_START);
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL end_refill_pulses: got %0d want 0", pulses);
    end
    row({8{8'd8}}, CTRL_START);
    total++;
    if (bus.res_valid !== 1'b1) begin
      bad++; $display("FAIL end_third_row_valid: got %b want 1", bus.res_valid);
    end
    for (int t = 0; t < 9; t++) fv[t] = 16'(6 + t / 3);
    exp_v = build();
    total++;
    if (bus.result !== exp_v) begin
      bad++; fi = first_diff(bus.result, exp_v);
      $display("FAIL end_result: field %0d got %h want %h", fi,
               bus.result[fi*16 +: 16], exp_v[fi*16 +: 16]);
    end
  endtask

  task automatic test_weight_coincide();
    int fi;
    do_reset();
    for (int t = 0; t < 9; t++) tw[t] = {8{8'h01}};
    load_w(9);
    for (int r = 0; r < 3; r++) row({8{8'h01}}, CTRL_HOLD);
    // New tap 0 written on the same edge as a firing row.
    bus.w_valid = 1'b1; bus.w_data = {8{8'h02}};
    row({8{8'h01}}, CTRL_START);
    bus.w_valid = 1'b0;
    for (int t = 0; t < 9; t++) fv[t] = 16'd1;
    exp_v = build();
    total++;
    if (bus.result !== exp_v || bus.res_valid !== 1'b1) begin
      bad++; fi = first_diff(bus.result, exp_v);
      $display("FAIL coincide_old_w: vld %b field %0d got %h want %h", bus.res_valid, fi,
               bus.result[fi*16 +: 16], exp_v[fi*16 +: 16]);
    end
    row({8{8'h01}}, CTRL_START);
    fv[0] = 16'd2;
    exp_v = build();
    total++;
    if (bus.result !== exp_v || bus.res_valid !== 1'b1) begin
      bad++; fi = first_diff(bus.result, exp_v);
      $display("FAIL coincide_new_w: vld %b field %0d got %h want %h", bus.res_valid, fi,
               bus.result[fi*16 +: 16], exp_v[fi*16 +: 16]);
    end
  endtask

  task automatic test_random();
    logic [63:0] rr [8];
    bit ws, is;
    int fi;
    for (int it = 0; it < 2; it++) begin
      do_reset();
      ws = (it == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      is = (it == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.w_format = ws ? FMT_SIGNED : 4'd0;
      bus.i_format = is ? FMT_SIGNED : 4'd5;
      for (int t = 0; t < 9; t++) tw[t] = {$urandom, $urandom};
      for (int r = 0; r < 8; r++) rr[r] = {$urandom, $urandom};
      load_w(10);
      pulses = 0;
      for (int r = 0; r < 8; r++) begin
        row(rr[r], (r < 2) ? CTRL_HOLD : CTRL_START);
        if (r >= 2) begin
          exp_v = model(rr[r-2], rr[r-1], rr[r], ws, is);
          total++;
          if (bus.result !== exp_v || bus.res_valid !== 1'b1) begin
            bad++; fi = first_diff(bus.result, exp_v);
            $display("FAIL random it%0d win%0d: vld %b field %0d got %h want %h", it, r - 2,
                     bus.res_valid, fi, bus.result[fi*16 +: 16], exp_v[fi*16 +: 16]);
          end
        end
      end
      total++;
      if (pulses != 6) begin
        bad++; $display("FAIL random_pulses it%0d: got %0d want 6", it, pulses);
      end
    end
  endtask

  task automatic test_reset_mid();
    int fi;
    do_reset();
    for (int t = 0; t < 9; t++) tw[t] = {8{8'h03}};
    load_w(9);
    for (int r = 0; r < 3; r++) row({8{8'h02}}, CTRL_HOLD);
    row({8{8'h02}}, CTRL_START);
    total++;
    if (bus.res_valid !== 1'b1) begin
      bad++; $display("FAIL midrst_pre_valid: got %b want 1", bus.res_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.res_valid !== 1'b0 || bus.result !== '0) begin
      bad++; fi = first_diff(bus.result, '0);
      $display("FAIL midrst_abort: vld %b field %0d got %h want 0", bus.res_valid, fi,
               bus.result[fi*16 +: 16]);
    end
    tick();
    rst_n = 1'b1;
    tick();
    // Weights and fill were cleared: third row fires with all-zero products.
    pulses = 0;
    row({8{8'h02}}, CTRL_START);
    row({8{8'h02}}, CTRL_START);
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL midrst_fill_cleared: got %0d want 0", pulses);
    end
    row({8{8'h02}}, CTRL_START);
    total++;
    if (bus.res_valid !== 1'b1 || bus.result !== '0) begin
      bad++; fi = first_diff(bus.result, '0);
      $display("FAIL midrst_w_cleared: vld %b field %0d got %h want 0", bus.res_valid, fi,
               bus.result[fi*16 +: 16]);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_signed();
    test_hold_end();
    test_weight_coincide();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ipf.md
# ipf

Input-times-filter product engine: 3×3 convolution partial-product generator in the accelerator datapath, between the input/weight line buffers and the downstream adder tree. It latches nine 64-bit weight words and streams 8-pixel input rows through a 3-row window. For every complete window it emits all 8 filters × 8 columns × 9 taps products, 16 bits each, as one 9216-bit result word.

## Interface
- In_Width, 8: pixel/weight element width (bits).
- Out_Width, 9: kernel taps per window.
- Addr_Width, 16: reserved, unused.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock, reset asynchronous active-low.
- ctrl  in  2  0 = end, 1 = start/compute, 2 = hold, 3 = hold. X/Z is treated as hold.
- i_valid  in  1  i_data carries an input row.
- i_data  in  64  row of 8 pixels; column b = i_data[8b+7:8b].
- w_valid  in  1  w_data carries a weight tap word.
- w_data  in  64  one tap for 8 filters; filter f = w_data[8f+7:8f].
- Wsize  in  2  kernel size; only 0 (3×3) is supported, other values behave as 0.
- i_format, w_format  in  4 each  element format: 2 = signed two's complement, any other value = unsigned.
- RLPadding  in  2  reserved, ignored.
- stride  in  1  reserved, ignored.
- wgroup  in  4  reserved, ignored.
- wround  in  3  reserved, ignored.
- res_valid  out  1  result valid, one-cycle pulse per window.
- result  out  9216  product array.

## Operation
- Weight load:
  - Each rising edge with w_valid=1 stores w_data into tap register W[wptr] and increments wptr.
  - wptr clears on reset and when w_valid was 0 in the previous cycle.
  - Writes beyond tap 8 are dropped.
  - Tap t = 3·ky + kx.
- Row window:
  - Each edge with i_valid=1 shifts i_data into a 3-row buffer: R0 oldest, R2 newest.
  - The fill count saturates at 3.
  - Shifting occurs for any ctrl value except 0.
  - ctrl=0 clears the fill count and does not shift.
- Compute fires on an edge with i_valid=1, ctrl=1 and fill count ≥2 before the edge, i.e. the incoming row completes the window.
  - The window is {R1, R2, i_data} as rows ky = 0, 1, 2.
- Product P(f,c,t) = W[t].byte f × pixel(row ky, column c+kx).
  - c = 0..7.
  - When c+kx > 7 the pixel is 0.
- Signedness:
  - An operand is sign-extended if its format = 2, zero-extended otherwise.
  - The product is truncated to 16 bits; all format combinations fit exactly.
- Packing: result[((f·8 + c)·9 + t)·16 +: 16] = P(f,c,t).
- ctrl = 2/3/X: rows still shift, no compute.

## Timing
- Reset: res_valid=0, result=0, all W=0, row buffer=0, fill=0, wptr=0.
- Latency:
  - res_valid and result are registered and appear the cycle after the firing edge.
  - res_valid is high for exactly one cycle per firing.
  - result holds its last value until the next firing.
- Throughput: one window per cycle, back-to-back.
- Weight and row inputs are independent. If w_valid and a firing coincide, the product uses the pre-edge W.
- Reset mid-stream aborts everything immediately; a pending res_valid is dropped.
- Ctrl sequence for 8 rows:
  - Rows 0 and 1 with ctrl hold/X.
  - ctrl=1 from row 2 through row 7.
  - Exactly 6 res_valid pulses.

## Structure
- Package ipf_pkg holds:
  - IN_W=8, TAPS=9, FILT=8, COLS=8, PROD_W=16.
  - RES_W = FILT·COLS·TAPS·PROD_W = 9216.
  - ctrl encodings CTRL_END/START/HOLD and FMT_SIGNED=2.
- Sub-module ipf_mac_slice:
  - One filter × 8 columns × 9 taps multiplier array.
  - Sign-mode inputs.
  - Instantiated 8 times.
- Top holds the weight registers, row shifter, control and output register.

## Test plan
- Reset check: assert rst_n=0 for 2 cycles → res_valid=0, result=0.
- All weights 1 (unsigned) and row r pixels = r+1:
  - 8 rows, ctrl=1 from row 2 → 6 pulses.
  - Window k field (f,c,t) = k+1+ky for c+kx≤7, else 0.
- Signed mode:
  - w_format=i_format=2, weights 0xFF (−1), pixels 0x80 (−128) → every in-range field = 0x0080.
  - The same data with both formats 1 → 0xFE01 (255×255 = 65025).
- Hold/end:
  - ctrl=2 during rows 2–4 → no pulses.
  - ctrl=0 for one cycle, then 2 rows → no pulse until a third row with ctrl=1.
- Random:
  - 9 random taps and 8 random rows, ctrl per the Timing ctrl sequence.
  - 6 results bit-exact against a software model, including the c+kx>7 zero fields.
